// File: rtl/mat_vec_serial_loader_pkg.sv
// Shared definitions for serial-feeder blocks: state encoding and the
// stream-length helper (N*N matrix bits followed by N vector bits).
package mat_vec_serial_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Number of serial beats needed for one N x N matrix plus an N-bit vector.
    function automatic int unsigned stream_len(input int unsigned n);
        return n * n + n;
    endfunction

endpackage

// File: rtl/mat_vec_serial_loader_if.sv
// Bundles the serial input stream, the multiplier operand/result wires and
// the result handshake of the loader. The slave side is the loader itself.
interface mat_vec_serial_loader_if #(
    parameter int N = 2
);
    logic             s_bit;
    logic             s_valid;
    logic             s_ready;
    logic [N*N-1:0]   m_a;
    logic [N-1:0]     m_v;
    logic             m_valid;
    logic [N-1:0]     u_in;
    logic [N-1:0]     u_out;
    logic             u_valid;
    logic             u_ready;

    modport slave (
        input  s_bit, s_valid, u_in, u_ready,
        output s_ready, m_a, m_v, m_valid, u_out, u_valid
    );

    modport master (
        output s_bit, s_valid, u_in, u_ready,
        input  s_ready, m_a, m_v, m_valid, u_out, u_valid
    );
endinterface

// File: rtl/mat_vec_serial_loader_sp_bit_capture.sv
// Serial-to-parallel register bank: writes one addressed bit per enabled
// cycle and keeps every other bit unchanged.
module sp_bit_capture #(
    parameter int W  = 4,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [IW-1:0] i_idx,
    input  logic          i_bit,
    output logic [W-1:0]  o_q
);

    logic [W-1:0] r_q;

    // Capture the incoming bit at its index; clear the whole bank on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q[i_idx] <= i_bit;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mat_vec_serial_loader.sv
// Sequencer around a combinational GF(2) matrix-vector multiplier: gathers
// A (column-major) and v from a 1-bit stream, presents them for one EVAL
// cycle, then holds the sampled result until the consumer takes it.
module mat_vec_serial_loader
    import mat_vec_serial_loader_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    mat_vec_serial_loader_if.slave  bus
);

    localparam int NN  = N * N;
    localparam int L   = stream_len(N);
    localparam int CW  = $clog2(L + 1);
    localparam int IWA = $clog2(NN);
    localparam int IWV = (N > 1) ? $clog2(N) : 1;

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_m_valid;
    logic            r_u_valid;
    logic [N-1:0]    r_u_out;

    logic            w_s_ready;
    logic            w_accept;
    logic            w_last;
    logic            w_we_a;
    logic            w_we_v;
    logic [IWA-1:0]  w_idx_a;
    logic [IWV-1:0]  w_idx_v;
    logic [NN-1:0]   w_m_a;
    logic [N-1:0]    w_m_v;

    // Decode the current beat: which bank it targets and whether it closes the stream.
    always_comb begin
        w_s_ready = 1'b0;
        w_accept  = 1'b0;
        w_last    = 1'b0;
        w_we_a    = 1'b0;
        w_we_v    = 1'b0;
        w_idx_a   = IWA'(r_cnt);
        w_idx_v   = IWV'(r_cnt - CW'(NN));
        if ((r_state == ST_LOAD) && !rst) begin
            w_s_ready = 1'b1;
        end else begin
            w_s_ready = 1'b0;
        end
        w_accept = w_s_ready && bus.s_valid;
        w_last   = (r_cnt == CW'(L - 1));
        if (r_cnt < CW'(NN)) begin
            w_we_a = w_accept;
        end else begin
            w_we_v = w_accept;
        end
    end

    sp_bit_capture #(.W(NN), .IW(IWA)) u_cap_a (
        .clk   (clk),
        .rst   (rst),
        .i_we  (w_we_a),
        .i_idx (w_idx_a),
        .i_bit (bus.s_bit),
        .o_q   (w_m_a)
    );

    sp_bit_capture #(.W(N), .IW(IWV)) u_cap_v (
        .clk   (clk),
        .rst   (rst),
        .i_we  (w_we_v),
        .i_idx (w_idx_v),
        .i_bit (bus.s_bit),
        .o_q   (w_m_v)
    );

    // LOAD -> EVAL -> HOLD sequencing with registered strobes and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_LOAD;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_u_valid <= 1'b0;
            r_u_out   <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_cnt     <= '0;
                            r_m_valid <= 1'b1;
                            r_state   <= ST_EVAL;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ST_EVAL: begin
                    r_u_out   <= bus.u_in;
                    r_u_valid <= 1'b1;
                    r_m_valid <= 1'b0;
                    r_state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.u_ready) begin
                        r_u_valid <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= ST_LOAD;
                    end
                end
                default: begin
                    r_state   <= ST_LOAD;
                    r_cnt     <= '0;
                    r_m_valid <= 1'b0;
                    r_u_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_a     = w_m_a;
    assign bus.m_v     = w_m_v;
    assign bus.m_valid = r_m_valid;
    assign bus.u_out   = r_u_out;
    assign bus.u_valid = r_u_valid;

endmodule

// File: tb/tb_mat_vec_serial_loader.sv
// Directed bench for mat_vec_serial_loader with N=2 (stream length 6).
// A behavioral GF(2) multiplier closes the loop on u_in.
module tb_mat_vec_serial_loader;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mat_vec_serial_loader_if #(.N(2)) bus ();

    mat_vec_serial_loader #(.N(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference multiplier: u_i = XOR_j (A_i_j & v_j), A_i_j at bit i + 2*j.
    function automatic logic [1:0] gf2_mul(input logic [3:0] a, input logic [1:0] v);
        logic [1:0] u;
        u = 2'b00;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                u[i] = u[i] ^ (a[i + 2*j] & v[j]);
            end
        end
        return u;
    endfunction

    assign bus.u_in = gf2_mul(bus.m_a, bus.m_v);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Beat k of the stream is bits[k]: bits[3:0]=A, bits[5:4]=v.
    task automatic send_stream(input logic [5:0] bits);
        for (int k = 0; k < 6; k++) begin
            bus.s_valid = 1'b1;
            bus.s_bit   = bits[k];
            step();
        end
        bus.s_valid = 1'b0;
        bus.s_bit   = 1'b0;
    endtask

    initial begin
        logic [5:0] bits;
        logic [3:0] a;
        logic [1:0] v;
        errors = 0;
        checks = 0;
        rst         = 1'b1;
        bus.s_bit   = 1'b0;
        bus.s_valid = 1'b0;
        bus.u_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_s_ready", bus.s_ready, 1'b0);
        chk("rst_m_a", bus.m_a, 4'b0000);
        chk("rst_m_v", bus.m_v, 2'b00);
        chk("rst_m_valid", bus.m_valid, 1'b0);
        chk("rst_u_valid", bus.u_valid, 1'b0);
        chk("rst_u_out", bus.u_out, 2'b00);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", bus.s_ready, 1'b1);

        // Identity A, v=(1,0)
        send_stream(6'b01_1001);
        chk("id_m_valid", bus.m_valid, 1'b1);
        chk("id_m_a", bus.m_a, 4'b1001);
        chk("id_m_v", bus.m_v, 2'b01);
        chk("id_eval_s_ready", bus.s_ready, 1'b0);
        chk("id_eval_u_valid", bus.u_valid, 1'b0);
        step();
        chk("id_u_valid", bus.u_valid, 1'b1);
        chk("id_u_out", bus.u_out, 2'b01);
        chk("id_m_valid_drop", bus.m_valid, 1'b0);
        step();
        chk("id_u_valid_1cyc", bus.u_valid, 1'b0);
        chk("id_back_load", bus.s_ready, 1'b1);

        // All-ones A, v=(1,1): parity cancels
        send_stream(6'b11_1111);
        step();
        chk("ones_v11_u_out", bus.u_out, 2'b00);
        chk("ones_v11_u_valid", bus.u_valid, 1'b1);
        step();
        // All-ones A, v=(1,0)
        send_stream(6'b01_1111);
        step();
        chk("ones_v10_u_out", bus.u_out, 2'b11);
        step();

        // Identity stream with s_valid toggling; gaps must not advance the count
        bits = 6'b01_1001;
        for (int k = 0; k < 6; k++) begin
            bus.s_valid = 1'b1;
            bus.s_bit   = bits[k];
            step();
            if (k < 5) begin
                chk($sformatf("gap_beat%0d_m_valid", k), bus.m_valid, 1'b0);
                bus.s_valid = 1'b0;
                bus.s_bit   = 1'b1;
                step();
                chk($sformatf("gap_idle%0d_m_valid", k), bus.m_valid, 1'b0);
            end
        end
        bus.s_valid = 1'b0;
        chk("gap_m_valid", bus.m_valid, 1'b1);
        chk("gap_m_a", bus.m_a, 4'b1001);
        chk("gap_m_v", bus.m_v, 2'b01);
        step();
        chk("gap_u_out", bus.u_out, 2'b01);
        step();

        // Back-pressure: result held while u_ready=0; offered bits are not taken
        bus.u_ready = 1'b0;
        send_stream(6'b01_1001);
        step();
        bus.s_valid = 1'b1;
        bus.s_bit   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("hold%0d_u_valid", c), bus.u_valid, 1'b1);
            chk($sformatf("hold%0d_u_out", c), bus.u_out, 2'b01);
            chk($sformatf("hold%0d_s_ready", c), bus.s_ready, 1'b0);
            step();
        end
        bus.u_ready = 1'b1;
        bus.s_valid = 1'b0;
        step();
        chk("release_s_ready", bus.s_ready, 1'b1);
        chk("release_u_valid", bus.u_valid, 1'b0);
        // u_ready high in LOAD is harmless; a fresh stream must hold no stray bits
        send_stream(6'b11_1111);
        chk("after_hold_m_a", bus.m_a, 4'b1111);
        chk("after_hold_m_v", bus.m_v, 2'b11);
        step();
        chk("after_hold_u_out", bus.u_out, 2'b00);
        step();

        // Reset after three accepted bits, then a fresh stream
        for (int k = 0; k < 3; k++) begin
            bus.s_valid = 1'b1;
            bus.s_bit   = 1'b1;
            step();
        end
        bus.s_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("midrst_s_ready", bus.s_ready, 1'b0);
        chk("midrst_m_a", bus.m_a, 4'b0000);
        chk("midrst_m_valid", bus.m_valid, 1'b0);
        chk("midrst_u_out", bus.u_out, 2'b00);
        rst = 1'b0;
        #1;
        chk("midrst_release_s_ready", bus.s_ready, 1'b1);
        send_stream(6'b11_0110);
        chk("midrst_m_valid_after", bus.m_valid, 1'b1);
        chk("midrst_new_m_a", bus.m_a, 4'b0110);
        step();
        chk("midrst_new_u_out", bus.u_out, 2'b11);
        step();

        // Back-to-back sweep of all 64 operand combinations, one result per 8 cycles
        bus.u_ready = 1'b1;
        bus.s_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            bits = 6'(t);
            a = bits[3:0];
            v = bits[5:4];
            for (int k = 0; k < 6; k++) begin
                bus.s_bit = bits[k];
                step();
            end
            chk($sformatf("b2b%0d_m_valid", t), bus.m_valid, 1'b1);
            chk($sformatf("b2b%0d_m_a", t), bus.m_a, a);
            bus.s_bit = 1'b1;
            step();
            chk($sformatf("b2b%0d_u_out", t), bus.u_out, gf2_mul(a, v));
            step();
        end
        bus.s_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mat_vec_serial_loader.md
Name: mat_vec_serial_loader

Overview:
- Upstream/downstream sequencer for the combinational binary matrix-vector multiplier.
- Assembles an N x N binary matrix A and an N-bit vector v from a 1-bit valid/ready serial stream.
- Presents A and v as stable parallel words with a strobe, captures the multiplier result u one cycle later, and holds it on a valid/ready output port until it is consumed.

Parameters:
- N, 2, matrix dimension; vector and result width. Legal range 2..8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- s_bit  input  1  serial data bit.
- s_valid  input  1  s_bit is valid this cycle.
- s_ready  output  1  block accepts s_bit this cycle.
- m_a  output  N*N  matrix to multiplier; element A_i_j at bit i + N*j.
- m_v  output  N  vector to multiplier; v_j at bit j.
- m_valid  output  1  m_a/m_v complete and stable (EVAL state).
- u_in  input  N  combinational result from multiplier; u_i at bit i.
- u_out  output  N  registered result.
- u_valid  output  1  u_out holds a fresh result.
- u_ready  input  1  consumer accepts u_out.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous, active-high.
- Reset state: state=LOAD, cnt=0, m_a=0, m_v=0, u_out=0, u_valid=0, m_valid=0.
  - s_ready=0 while rst is high.
  - s_ready=1 in the first cycle after rst deasserts.
- Bit acceptance: a bit is accepted on a clock edge when s_valid && s_ready.
- Stream order: total L=N*N+N bits.
  - Beats k=0..N*N-1 write m_a[k]. Column-major: A_0_0, A_1_0, …, A_(N-1)_0, A_0_1, …
  - Beats k=N*N..L-1 write m_v[k-N*N].
- Counter: cnt of width clog2(L+1), incremented per accepted bit, cleared on leaving LOAD.
- States:
  - LOAD: s_ready=1, m_valid=0, u_valid=0.
    - On accepting beat L-1: write that bit and go to EVAL.
    - Bits with s_valid=0 are ignored; cnt holds.
  - EVAL: exactly one cycle. s_ready=0, m_valid=1, m_a/m_v stable.
    - At the end of the cycle: u_out<=u_in, u_valid<=1, go to HOLD.
  - HOLD: s_ready=0, m_valid=0, u_valid=1; u_out, m_a, m_v held.
    - If u_ready=1: u_valid<=0, cnt<=0, go to LOAD.
- Latency:
  - m_valid rises in the cycle after the edge accepting beat L-1.
  - u_valid rises one cycle after that.
  - Minimum transaction = L+2 cycles when u_ready is tied high.
- Multiplier contract: u_in depends only on m_a/m_v and is sampled only in EVAL. u_i = XOR over j of (A_i_j AND v_j), i.e. GF(2) arithmetic.
- Buffer reuse: on re-entry to LOAD, m_a/m_v keep old contents until overwritten beat by beat. Downstream uses them only while m_valid=1.
- Edge cases:
  - u_ready high while in LOAD or EVAL has no effect.
  - s_valid high outside LOAD: the bit is not accepted, and the upstream holds it.
  - rst mid-load or mid-HOLD: all state returns to reset values on that edge; a partial stream or pending result is discarded.
  - u_valid must not drop without u_ready.
  - u_out must not change while u_valid=1.

Decomposition:
- Shared include file holds the state encodings (LOAD=2'd0, EVAL=2'd1, HOLD=2'd2) and an L = N*N+N length macro/function, shared with future serial-feeder blocks.
- One natural sub-module: sp_bit_capture.
  - Parameterised-width register bank with write-enable and bit index; writes one bit per cycle.
  - Instantiated twice: width N*N for m_a, width N for m_v.

Test Plan (N=2, L=6; bench drives u_in from a GF(2) behavioral model of the multiplier):
- Identity A (stream 1,0,0,1), v=(v_0=1,v_1=0), u_ready=1 → m_valid pulses 1 cycle with m_a=4'b1001, m_v=2'b01; next cycle u_out=2'b01, u_valid=1 for exactly 1 cycle.
- A all ones (1,1,1,1), v=(1,1) → u_out=2'b00 (parity cancels); v=(1,0) → u_out=2'b11.
- s_valid toggled 1/0 every cycle over the same identity stream → m_valid rises 1 cycle after the 6th accepted bit; gaps do not advance cnt.
- u_ready held 0 for 10 cycles after u_valid → u_valid and u_out stable, s_ready=0 throughout; u_ready=1 → next cycle s_ready=1, u_valid=0.
- rst asserted after 3 accepted bits, then a fresh full stream (A=0110, v=11) → u_out=2'b11, no residue from the aborted load.
- Back-to-back transactions with u_ready=1 and s_valid=1 continuously → one result every 8 cycles; all 64 combinations of 4 A bits × 2 v bits match the model.
